// File: rtl/tl_ul_protocol_monitor.sv
// rtl/tl_ul_protocol_monitor.sv - passive TileLink-UL A/D channel protocol checker
// Define TL_MON_TIMEOUT_EN to add the response watchdog (violation code 13).
module tl_ul_protocol_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2,
  parameter int SIZE_W  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SRC_W-1:0]    d_source,
  input  logic                d_denied,
  output logic                err_pulse,
  output logic [3:0]          err_code,
  output logic [15:0]         err_count,
  output logic [SRC_W:0]      outstanding
);
  localparam int BYTES    = DATA_W / 8;
  localparam int LANE_LOG = $clog2(BYTES);
  localparam int NSRC     = 1 << SRC_W;
  localparam int BEAT_W   = (1 << SIZE_W) + 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  function automatic logic [BEAT_W-1:0] beats(input logic [SIZE_W-1:0] sz);
    if (int'(sz) > LANE_LOG) return BEAT_W'(1) << (int'(sz) - LANE_LOG);
    return BEAT_W'(1);
  endfunction

  logic [NSRC-1:0]   tbl_valid, tbl_valid_nxt;
  logic [2:0]        tbl_op   [NSRC];
  logic [SIZE_W-1:0] tbl_size [NSRC];

  // a_rem/d_rem hold beats still owed after the current one; zero means the next beat is a first beat
  logic [BEAT_W-1:0] a_rem, d_rem;
  logic [2:0]        a_op_q, a_param_q, d_op_q;
  logic [SIZE_W-1:0] a_size_q, d_size_q;
  logic [SRC_W-1:0]  a_src_q, d_src_q;

  logic              a_stall_q, d_stall_q;
  logic [2:0]        sa_op, sa_param, sd_op;
  logic [SIZE_W-1:0] sa_size, sd_size;
  logic [SRC_W-1:0]  sa_src, sd_src;
  logic [ADDR_W-1:0] sa_addr;
  logic [BYTES-1:0]  sa_mask;
  logic              sd_denied;

  logic              a_fire, d_fire, a_first, d_first, d_last, d_release, a_busy, a_misalign;
  logic [BEAT_W-1:0] a_nbeats, d_nbeats;
  logic [BYTES-1:0]  a_full_mask;
  logic [ADDR_W-1:0] lane_off;
  logic [13:1]       viol;
  logic [3:0]        code;
  logic [SRC_W:0]    pop_nxt;
  logic              wd_hit;

  assign a_fire    = a_valid & a_ready;
  assign d_fire    = d_valid & d_ready;
  assign a_first   = (a_rem == '0);
  assign d_first   = (d_rem == '0);
  assign a_nbeats  = (a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PART) ? beats(a_size) : BEAT_W'(1);
  assign d_nbeats  = (d_opcode == OP_ACK_DATA) ? beats(d_size) : BEAT_W'(1);
  assign d_last    = d_first ? (d_nbeats == BEAT_W'(1)) : (d_rem == BEAT_W'(1));
  assign d_release = d_fire & d_last;
  // A response retiring this source in the same cycle frees it for the new request
  assign a_busy    = tbl_valid[a_source] & ~(d_release & (d_source == a_source));
  assign lane_off  = a_address & ADDR_W'(BYTES - 1);
  assign a_misalign = (int'(a_size) >= ADDR_W) ||
                      ((a_address & ((ADDR_W'(1) << a_size) - ADDR_W'(1))) != '0);

  always_comb begin
    a_full_mask = '0;
    for (int i = 0; i < BYTES; i++)
      a_full_mask[i] = (int'(a_size) >= LANE_LOG) || ((ADDR_W'(i) >> a_size) == (lane_off >> a_size));
  end

  always_comb begin
    viol = '0;
    if (a_valid) begin
      viol[1] = !(a_opcode inside {OP_PUT_FULL, OP_PUT_PART, OP_GET});
      viol[2] = (a_param != 3'd0);
      viol[3] = a_misalign;
      viol[4] = (a_opcode == OP_PUT_FULL || a_opcode == OP_GET) && (a_mask != a_full_mask);
      viol[5] = a_first & a_busy;
      viol[6] = !a_first && (a_opcode != a_op_q || a_size != a_size_q ||
                             a_source != a_src_q || a_param != a_param_q);
    end
    viol[7] = a_stall_q && (!a_valid || a_opcode != sa_op || a_param != sa_param ||
                            a_size != sa_size || a_source != sa_src ||
                            a_address != sa_addr || a_mask != sa_mask);
    if (d_valid) begin
      viol[8] = d_first & ~tbl_valid[d_source];
      if (tbl_valid[d_source]) begin
        viol[9]  = d_opcode != ((tbl_op[d_source] == OP_GET) ? OP_ACK_DATA : OP_ACK);
        viol[10] = d_size != tbl_size[d_source];
      end
      viol[11] = !d_first && (d_opcode != d_op_q || d_size != d_size_q || d_source != d_src_q);
    end
    viol[12] = d_stall_q && (!d_valid || d_opcode != sd_op || d_size != sd_size ||
                             d_source != sd_src || d_denied != sd_denied);
    viol[13] = wd_hit;
  end

  always_comb begin
    code = 4'd0;
    for (int c = 13; c >= 1; c--)
      if (viol[c]) code = 4'(c);
  end

  always_comb begin
    tbl_valid_nxt = tbl_valid;
    if (d_release) tbl_valid_nxt[d_source] = 1'b0;
    if (a_fire && a_first) tbl_valid_nxt[a_source] = 1'b1;
    pop_nxt = '0;
    for (int s = 0; s < NSRC; s++)
      pop_nxt = pop_nxt + (SRC_W + 1)'(tbl_valid_nxt[s]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid   <= '0;
      outstanding <= '0;
      a_rem       <= '0;
      d_rem       <= '0;
      a_stall_q   <= 1'b0;
      d_stall_q   <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= 4'd0;
      err_count   <= 16'd0;
    end else begin
      tbl_valid   <= tbl_valid_nxt;
      outstanding <= pop_nxt;
      a_stall_q   <= a_valid & ~a_ready;
      d_stall_q   <= d_valid & ~d_ready;
      if (a_fire) a_rem <= a_first ? a_nbeats - BEAT_W'(1) : a_rem - BEAT_W'(1);
      if (d_fire) d_rem <= d_first ? d_nbeats - BEAT_W'(1) : d_rem - BEAT_W'(1);
      err_pulse <= |viol;
      if (|viol && err_code == 4'd0) err_code <= code;
      if (|viol && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  // Payload registers are only read when qualified by the flags above, so they need no reset
  always_ff @(posedge clock) begin
    if (a_fire && a_first) begin
      tbl_op[a_source]   <= a_opcode;
      tbl_size[a_source] <= a_size;
      a_op_q             <= a_opcode;
      a_param_q          <= a_param;
      a_size_q           <= a_size;
      a_src_q            <= a_source;
    end
    if (d_fire && d_first) begin
      d_op_q   <= d_opcode;
      d_size_q <= d_size;
      d_src_q  <= d_source;
    end
    sa_op     <= a_opcode;
    sa_param  <= a_param;
    sa_size   <= a_size;
    sa_src    <= a_source;
    sa_addr   <= a_address;
    sa_mask   <= a_mask;
    sd_op     <= d_opcode;
    sd_size   <= d_size;
    sd_src    <= d_source;
    sd_denied <= d_denied;
  end

`ifdef TL_MON_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_hit = (outstanding != '0) && !d_fire && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || outstanding == '0 || d_fire || wd_hit) wd_cnt <= 16'd0;
    else                                                wd_cnt <= wd_cnt + 16'd1;
  end
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_protocol_monitor.sv
// tb/tb_tl_ul_protocol_monitor.sv - directed and randomized bench for tl_ul_protocol_monitor
module tb_tl_ul_protocol_monitor;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;
  localparam int SIZE_W = 3;
  localparam int BYTES  = DATA_W / 8;
  localparam int NSRC   = 1 << SRC_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              a_valid, a_ready, d_valid, d_ready, d_denied;
  logic [2:0]        a_opcode, a_param, d_opcode;
  logic [SIZE_W-1:0] a_size, d_size;
  logic [SRC_W-1:0]  a_source, d_source;
  logic [ADDR_W-1:0] a_address;
  logic [BYTES-1:0]  a_mask;
  logic              err_pulse;
  logic [3:0]        err_code;
  logic [15:0]       err_count;
  logic [SRC_W:0]    outstanding;

  always #5 clock = ~clock;

  tl_ul_protocol_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied),
    .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count), .outstanding(outstanding)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: link state kept as plain arrays and beat counts
  bit     m_valid [NSRC];
  int     m_op    [NSRC];
  int     m_size  [NSRC];
  int     ma_done, ma_total, ma_op, ma_param, ma_size, ma_src;
  int     md_done, md_total, md_op, md_size, md_src;
  bit     pa_stall, pd_stall;
  int     pa_op, pa_param, pa_size, pa_src, pa_mask;
  longint pa_addr;
  int     pd_op, pd_size, pd_src, pd_den;
  bit     e_pulse;
  int     e_code, e_count;
  int     dr_a_left, dr_d_left;

  function automatic int beats_of(input int sz);
    int bytes = 1 << sz;
    return (bytes <= BYTES) ? 1 : bytes / BYTES;
  endfunction

  function automatic int full_mask(input int sz, input longint addr);
    int bytes = 1 << sz;
    if (bytes >= BYTES) return (1 << BYTES) - 1;
    return ((1 << bytes) - 1) << ((int'(addr % BYTES) / bytes) * bytes);
  endfunction

  task automatic model_reset();
    foreach (m_valid[s]) m_valid[s] = 1'b0;
    ma_done = 0; md_done = 0; pa_stall = 1'b0; pd_stall = 1'b0;
    e_pulse = 1'b0; e_code = 0; e_count = 0;
    dr_a_left = 0; dr_d_left = 0;
  endtask

  task automatic model_step();
    bit [13:0] v = '0;
    bit af = a_valid && a_ready;
    bit df = d_valid && d_ready;
    int atot = (ma_done == 0) ? ((a_opcode <= 1) ? beats_of(int'(a_size)) : 1) : ma_total;
    int dtot = (md_done == 0) ? ((d_opcode == 1) ? beats_of(int'(d_size)) : 1) : md_total;
    bit dlast = (md_done + 1 == dtot);
    int first = 0;
    if (a_valid) begin
      v[1] = !(a_opcode == 0 || a_opcode == 1 || a_opcode == 4);
      v[2] = a_param != 0;
      v[3] = (a_size >= ADDR_W) || ((longint'(a_address) % (longint'(1) << a_size)) != 0);
      v[4] = (a_opcode == 0 || a_opcode == 4) && (int'(a_mask) != full_mask(int'(a_size), longint'(a_address)));
      if (ma_done == 0) v[5] = m_valid[a_source] && !(df && dlast && d_source == a_source);
      else v[6] = a_opcode != ma_op || a_size != ma_size || a_source != ma_src || a_param != ma_param;
    end
    v[7] = pa_stall && (!a_valid || a_opcode != pa_op || a_param != pa_param || a_size != pa_size ||
                        a_source != pa_src || longint'(a_address) != pa_addr || a_mask != pa_mask);
    if (d_valid) begin
      v[8] = (md_done == 0) && !m_valid[d_source];
      if (m_valid[d_source]) begin
        v[9]  = d_opcode != ((m_op[d_source] == 4) ? 1 : 0);
        v[10] = d_size != m_size[d_source];
      end
      if (md_done != 0) v[11] = d_opcode != md_op || d_size != md_size || d_source != md_src;
    end
    v[12] = pd_stall && (!d_valid || d_opcode != pd_op || d_size != pd_size ||
                         d_source != pd_src || d_denied != pd_den);
    for (int c = 12; c >= 1; c--) if (v[c]) first = c;
    e_pulse = (first != 0);
    if (first != 0 && e_code == 0) e_code = first;
    if (first != 0 && e_count < 65535) e_count++;
    if (df && dlast) m_valid[d_source] = 1'b0;
    if (af && ma_done == 0) begin
      m_valid[a_source] = 1'b1;
      m_op[a_source]    = a_opcode;
      m_size[a_source]  = a_size;
    end
    if (af) begin
      if (ma_done == 0) begin
        ma_total = atot; ma_op = a_opcode; ma_param = a_param; ma_size = a_size; ma_src = a_source;
      end
      ma_done++;
      if (ma_done == ma_total) ma_done = 0;
    end
    if (df) begin
      if (md_done == 0) begin
        md_total = dtot; md_op = d_opcode; md_size = d_size; md_src = d_source;
      end
      md_done++;
      if (md_done == md_total) md_done = 0;
    end
    pa_stall = a_valid && !a_ready;
    pa_op = a_opcode; pa_param = a_param; pa_size = a_size; pa_src = a_source;
    pa_addr = longint'(a_address); pa_mask = a_mask;
    pd_stall = d_valid && !d_ready;
    pd_op = d_opcode; pd_size = d_size; pd_src = d_source; pd_den = d_denied;
  endtask

  task automatic step();
    int exp_out = 0;
    model_step();
    @(posedge clock);
    #1;
    foreach (m_valid[s]) exp_out += int'(m_valid[s]);
    check_eq("err_pulse", int'(err_pulse), int'(e_pulse));
    check_eq("err_code", int'(err_code), e_code);
    check_eq("err_count", int'(err_count), e_count);
    check_eq("outstanding", int'(outstanding), exp_out);
  endtask

  task automatic drive_a(input bit v, input int op, input int sz, input int src,
                         input longint addr, input int mask, input bit rdy);
    a_valid = v; a_opcode = 3'(op); a_param = 3'd0; a_size = SIZE_W'(sz);
    a_source = SRC_W'(src); a_address = ADDR_W'(addr); a_mask = BYTES'(mask); a_ready = rdy;
  endtask

  task automatic drive_d(input bit v, input int op, input int sz, input int src, input bit rdy);
    d_valid = v; d_opcode = 3'(op); d_size = SIZE_W'(sz); d_source = SRC_W'(src);
    d_ready = rdy; d_denied = 1'b0;
  endtask

  task automatic do_reset();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    drive_d(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check_eq("rst_pulse", int'(err_pulse), 0);
    check_eq("rst_code", int'(err_code), 0);
    check_eq("rst_count", int'(err_count), 0);
    check_eq("rst_outstanding", int'(outstanding), 0);
  endtask

  task automatic new_request();
    int r   = $urandom % 16;
    int src = $urandom % NSRC;
    int op;
    for (int k = 0; k < 4 && m_valid[src] && ($urandom % 8 != 0); k++) src = $urandom % NSRC;
    op = (r < 5) ? 0 : (r < 8) ? 1 : (r < 15) ? 4 : 2 + ($urandom % 2);
    a_opcode  = 3'(op);
    a_source  = SRC_W'(src);
    a_size    = SIZE_W'($urandom % 5);
    a_address = ADDR_W'(($urandom % 64) << a_size);
    if ($urandom % 24 == 0) a_address = a_address + 1;
    a_param   = ($urandom % 32 == 0) ? 3'd1 : 3'd0;
    a_mask    = BYTES'(full_mask(int'(a_size), longint'(a_address)));
    if (op == 1 && ($urandom % 2 == 0)) a_mask = a_mask & BYTES'($urandom);
    if ($urandom % 32 == 0) a_mask = a_mask ^ BYTES'(1);
    dr_a_left = (op <= 1) ? beats_of(int'(a_size)) : 1;
    a_valid   = 1'b1;
  endtask

  task automatic new_response();
    int src   = $urandom % NSRC;
    bit found = 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (!found && m_valid[(src + k) % NSRC]) begin
        src = (src + k) % NSRC;
        found = 1'b1;
      end
    if (!found && ($urandom % 16 != 0)) begin
      d_valid = 1'b0;
      return;
    end
    d_source = SRC_W'(src);
    d_opcode = (found && m_op[src] == 4) ? 3'd1 : 3'd0;
    if ($urandom % 40 == 0) d_opcode = d_opcode ^ 3'd1;
    d_size   = found ? SIZE_W'(m_size[src]) : SIZE_W'($urandom % 3);
    if ($urandom % 40 == 0) d_size = d_size + 1'b1;
    d_denied = 1'($urandom % 2);
    dr_d_left = (d_opcode == 3'd1) ? beats_of(int'(d_size)) : 1;
    d_valid  = 1'b1;
  endtask

  task automatic rand_drive();
    bit af = a_valid && a_ready;
    bit df = d_valid && d_ready;
    bit a_stalled = a_valid && !a_ready;
    bit d_stalled = d_valid && !d_ready;
    if (af && dr_a_left > 0) dr_a_left--;
    if (df && dr_d_left > 0) dr_d_left--;
    if (a_stalled) begin
      if ($urandom % 40 == 0) a_address = a_address ^ ADDR_W'(4);
      else if ($urandom % 40 == 0) a_valid = 1'b0;
    end else if (dr_a_left > 0) begin
      a_valid = ($urandom % 8 != 0);
      if ($urandom % 40 == 0) a_size = a_size + 1'b1;
    end else if ($urandom % 2 == 0) new_request();
    else a_valid = 1'b0;
    a_ready = ($urandom % 3 != 0);
    if (d_stalled) begin
      if ($urandom % 40 == 0) d_valid = 1'b0;
      else if ($urandom % 40 == 0) d_denied = !d_denied;
    end else if (dr_d_left > 0) begin
      d_valid = ($urandom % 8 != 0);
      if ($urandom % 50 == 0) d_source = d_source + 1'b1;
    end else if ($urandom % 2 == 0) new_response();
    else d_valid = 1'b0;
    d_ready = ($urandom % 3 != 0);
  endtask

  initial begin
    do_reset();

    // single-beat Get and its data response
    drive_a(1, 4, 2, 0, 'h100, 'hF, 1); step();
    check_eq("get_outstanding_1", int'(outstanding), 1);
    drive_a(0, 0, 0, 0, 0, 0, 0); drive_d(1, 1, 2, 0, 1); step();
    check_eq("get_outstanding_0", int'(outstanding), 0);
    check_eq("get_code", int'(err_code), 0);
    drive_d(0, 0, 0, 0, 0);

    // 16-byte PutFull: four A beats then one AccessAck
    for (int b = 0; b < 4; b++) begin drive_a(1, 0, 4, 1, 'h200, 'hF, 1); step(); end
    drive_a(0, 0, 0, 0, 0, 0, 0); drive_d(1, 0, 4, 1, 1); step();
    check_eq("putfull_code", int'(err_code), 0);
    check_eq("putfull_outstanding", int'(outstanding), 0);
    drive_d(0, 0, 0, 0, 0);
    for (int b = 0; b < 3; b++) begin drive_a(1, 0, (b == 2) ? 3 : 4, 2, 'h200, 'hF, 1); step(); end
    check_eq("burst_change_code", int'(err_code), 6);
    check_eq("burst_change_pulse", int'(err_pulse), 1);

    // A stall with address change
    do_reset();
    drive_a(1, 4, 2, 0, 'h40, 'hF, 0); step();
    check_eq("stall_quiet", int'(err_pulse), 0);
    drive_a(1, 4, 2, 0, 'h44, 'hF, 0); step();
    check_eq("stall_pulse", int'(err_pulse), 1);
    check_eq("stall_code", int'(err_code), 7);
    check_eq("stall_count", int'(err_count), 1);
    drive_a(1, 4, 2, 0, 'h44, 'hF, 1); step();
    check_eq("stall_release_pulse", int'(err_pulse), 0);

    // unrequested response, then a misaligned Get keeps the first code
    do_reset();
    drive_d(1, 0, 2, 3, 1); step();
    check_eq("orphan_code", int'(err_code), 8);
    drive_d(0, 0, 0, 0, 0); drive_a(1, 4, 2, 0, 'h102, 'hF, 1); step();
    check_eq("sticky_code", int'(err_code), 8);
    check_eq("sticky_count", int'(err_count), 2);

    // release and re-allocate the same source in one cycle
    do_reset();
    drive_a(1, 4, 2, 1, 'h10, 'hF, 1); step();
    drive_d(1, 1, 2, 1, 1); step();
    check_eq("reuse_pulse", int'(err_pulse), 0);
    check_eq("reuse_outstanding", int'(outstanding), 1);

    // randomized traffic; each phase ends with a reset that may cut bursts short
    for (int ph = 0; ph < 24; ph++) begin
      do_reset();
      for (int cyc = 0; cyc < 120; cyc++) begin
        rand_drive();
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
